// File: rtl/rrd_pkg.sv
// rrd_pkg: operand/immediate select encodings, ctrl layout and the
// shared immediate expander for the register-read operand paths.
package rrd_pkg;

  localparam logic [1:0] OP1_RS1  = 2'd0;
  localparam logic [1:0] OP1_ZERO = 2'd1;
  localparam logic [1:0] OP1_PC   = 2'd2;

  localparam logic [2:0] OP2_RS2  = 3'd0;
  localparam logic [2:0] OP2_IMM  = 3'd1;
  localparam logic [2:0] OP2_ZERO = 3'd2;
  localparam logic [2:0] OP2_NEXT = 3'd3;
  localparam logic [2:0] OP2_IMMC = 3'd4;

  localparam logic [2:0] IMM_S = 3'd0;
  localparam logic [2:0] IMM_B = 3'd1;
  localparam logic [2:0] IMM_U = 3'd2;
  localparam logic [2:0] IMM_J = 3'd3;
  localparam logic [2:0] IMM_I = 3'd4;
  localparam logic [2:0] IMM_Z = 3'd5;

  localparam int CTRL_W       = 14;
  localparam int CTRL_BR_TYPE = 10;
  localparam int CTRL_OP_FCN  = 6;
  localparam int CTRL_FCN_DW  = 5;
  localparam int CTRL_CSR_CMD = 2;
  localparam int CTRL_PAD     = 0;

  typedef struct packed {
    logic [3:0] br_type;
    logic [3:0] op_fcn;
    logic       fcn_dw;
    logic [2:0] csr_cmd;
    logic [1:0] pad;
  } ctrl_t;

  // Packed layout: ip[19] sign, ip[18:9] imm[10:1], ip[8] imm[0]/imm[11],
  // ip[7:0] imm[19:12]; U-type reuses ip[19:8] as imm[31:20].
  function automatic logic [31:0] expand_imm(
    input logic [19:0] imm_packed,
    input logic [2:0]  imm_sel,
    input logic [4:0]  prs1
  );
    logic        sgn;
    logic        is_u;
    logic        is_uj;
    logic        is_jb;
    logic        is_si;
    logic [31:0] r;
    sgn   = imm_packed[19];
    is_u  = imm_sel == IMM_U;
    is_uj = is_u || imm_sel == IMM_J;
    is_jb = imm_sel == IMM_J || imm_sel == IMM_B;
    is_si = imm_sel == IMM_S || imm_sel == IMM_I;
    r[31:20] = is_u ? imm_packed[19:8] : {12{sgn}};
    r[19:12] = is_uj ? imm_packed[7:0] : {8{sgn}};
    r[11]    = is_u ? 1'b0 : (is_jb ? imm_packed[8] : sgn);
    r[10:1]  = is_u ? 10'd0 : imm_packed[18:9];
    r[0]     = is_si ? imm_packed[8] : 1'b0;
    unique case (1'b1)
      imm_sel == IMM_Z: r = {27'd0, prs1};
      imm_sel >  IMM_Z: r = '0;
      default: ;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/rrd_operand_stage_if.sv
// Uop-in and operand-out handshake bundles for the operand stage.
// io_in gains prs2 when RRD_WB_BYPASS_EN is defined.
interface rrd_in_if #(
  parameter int XLEN   = 64,
  parameter int MAX_BR = 8,
  parameter int PC_W   = 40
);
  logic              valid;
  logic              ready;
  logic [1:0]        op1_sel;
  logic [2:0]        op2_sel;
  logic [2:0]        imm_sel;
  logic [19:0]       imm_packed;
  logic              is_rvc;
  logic [6:0]        prs1;
`ifdef RRD_WB_BYPASS_EN
  logic [6:0]        prs2;
`endif
  logic [MAX_BR-1:0] br_mask;
  logic [13:0]       ctrl;
  logic [PC_W-1:0]   pc;
  logic [XLEN-1:0]   rs1_data;
  logic [XLEN-1:0]   rs2_data;

  modport master (
    output valid, op1_sel, op2_sel, imm_sel,
    output imm_packed, is_rvc, prs1,
`ifdef RRD_WB_BYPASS_EN
    output prs2,
`endif
    output br_mask, ctrl, pc, rs1_data, rs2_data,
    input  ready
  );

  modport slave (
    input  valid, op1_sel, op2_sel, imm_sel,
    input  imm_packed, is_rvc, prs1,
`ifdef RRD_WB_BYPASS_EN
    input  prs2,
`endif
    input  br_mask, ctrl, pc, rs1_data, rs2_data,
    output ready
  );
endinterface

interface rrd_out_if #(
  parameter int XLEN   = 64,
  parameter int MAX_BR = 8
);
  logic              valid;
  logic              ready;
  logic [XLEN-1:0]   op1;
  logic [XLEN-1:0]   op2;
  logic [13:0]       ctrl;
  logic [MAX_BR-1:0] br_mask;

  modport master (
    output valid, op1, op2, ctrl, br_mask,
    input  ready
  );

  modport slave (
    input  valid, op1, op2, ctrl, br_mask,
    output ready
  );
endinterface

// File: rtl/rrd_imm_gen.sv
// rrd_imm_gen: combinational immediate expander, sign-extended to XLEN.
// Shared by the integer, FP and memory register-read paths.
module rrd_imm_gen
  import rrd_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [19:0]     imm_packed,
  input  logic [2:0]      imm_sel,
  input  logic [4:0]      zimm,
  output logic [XLEN-1:0] imm
);

  logic [31:0] imm32;

  assign imm32 = expand_imm(imm_packed, imm_sel, zimm);
  assign imm   = {{(XLEN-32){imm32[31]}}, imm32};

endmodule

// File: rtl/rrd_operand_stage.sv
// rrd_operand_stage: selects and registers the operand pair for execute.
// Optional RRD_WB_BYPASS_EN forwards writeback data onto rs1/rs2.
module rrd_operand_stage
  import rrd_pkg::*;
#(
  parameter int XLEN   = 64,
  parameter int MAX_BR = 8,
  parameter int PC_W   = 40
) (
  input  logic              clock,
  input  logic              reset,
  rrd_in_if.slave           io_in,
  rrd_out_if.master         io_out,
  input  logic [MAX_BR-1:0] io_brupd_resolve_mask,
  input  logic [MAX_BR-1:0] io_brupd_mispredict_mask,
  input  logic              io_flush
`ifdef RRD_WB_BYPASS_EN
  ,
  input  logic              io_wb_valid,
  input  logic [6:0]        io_wb_pdst,
  input  logic [XLEN-1:0]   io_wb_data
`endif
);

  logic              v;
  logic [XLEN-1:0]   op1_q;
  logic [XLEN-1:0]   op2_q;
  logic [13:0]       ctrl_q;
  logic [MAX_BR-1:0] mask_q;

  logic [XLEN-1:0]   imm;
  logic [XLEN-1:0]   rs1;
  logic [XLEN-1:0]   rs2;
  logic [XLEN-1:0]   op1_d;
  logic [XLEN-1:0]   op2_d;
  logic              accept;
  logic              in_kill;
  logic              held_kill;
  logic              capture;

  rrd_imm_gen #(
    .XLEN(XLEN)
  ) u_imm_gen (
    .imm_packed(io_in.imm_packed),
    .imm_sel   (io_in.imm_sel),
    .zimm      (io_in.prs1[4:0]),
    .imm       (imm)
  );

`ifdef RRD_WB_BYPASS_EN
  logic hit1;
  logic hit2;
  // Physical register 0 is hardwired and never forwarded.
  assign hit1 = io_wb_valid && io_wb_pdst != 7'd0
             && io_wb_pdst == io_in.prs1;
  assign hit2 = io_wb_valid && io_wb_pdst != 7'd0
             && io_wb_pdst == io_in.prs2;
  assign rs1 = hit1 ? io_wb_data : io_in.rs1_data;
  assign rs2 = hit2 ? io_wb_data : io_in.rs2_data;
`else
  logic unused_prs1_hi;
  assign unused_prs1_hi = ^io_in.prs1[6:5];
  assign rs1 = io_in.rs1_data;
  assign rs2 = io_in.rs2_data;
`endif

  always_comb begin
    op1_d = '0;
    unique case (1'b1)
      io_in.op1_sel == OP1_RS1:  op1_d = rs1;
      io_in.op1_sel == OP1_ZERO: op1_d = '0;
      io_in.op1_sel == OP1_PC:   op1_d = XLEN'(io_in.pc);
      default: ;
    endcase
  end

  always_comb begin
    op2_d = '0;
    unique case (1'b1)
      io_in.op2_sel == OP2_RS2:  op2_d = rs2;
      io_in.op2_sel == OP2_IMM:  op2_d = imm;
      io_in.op2_sel == OP2_ZERO: op2_d = '0;
      io_in.op2_sel == OP2_NEXT:
        op2_d = {{(XLEN-3){1'b0}}, ~io_in.is_rvc,
                 io_in.is_rvc, 1'b0};
      io_in.op2_sel == OP2_IMMC:
        op2_d = {{(XLEN-5){1'b0}}, io_in.prs1[4:0]};
      default: ;
    endcase
  end

  assign io_in.ready = !v || io_out.ready;
  assign accept      = io_in.valid && io_in.ready;
  assign in_kill     = io_flush
                    || |(io_in.br_mask & io_brupd_mispredict_mask);
  assign held_kill   = io_flush
                    || |(mask_q & io_brupd_mispredict_mask);
  assign capture     = accept && !in_kill;

  // Operand registers only move on capture, so a stall holds them.
  always_ff @(posedge clock) begin
    if (reset) begin
      v      <= 1'b0;
      op1_q  <= '0;
      op2_q  <= '0;
      ctrl_q <= '0;
      mask_q <= '0;
    end else if (capture) begin
      v      <= 1'b1;
      op1_q  <= op1_d;
      op2_q  <= op2_d;
      ctrl_q <= io_in.ctrl;
      mask_q <= io_in.br_mask & ~io_brupd_resolve_mask;
    end else begin
      if (held_kill || io_out.ready) v <= 1'b0;
      mask_q <= mask_q & ~io_brupd_resolve_mask;
    end
  end

  assign io_out.valid   = v;
  assign io_out.op1     = op1_q;
  assign io_out.op2     = op2_q;
  assign io_out.ctrl    = ctrl_q;
  assign io_out.br_mask = mask_q;

endmodule

// File: tb/tb_rrd_operand_stage.sv
// Scoreboard bench for rrd_operand_stage: directed uops in,
// monitor compares each accepted output against the queued expectation.
module tb_rrd_operand_stage;
  import rrd_pkg::*;

  localparam int XLEN   = 64;
  localparam int MAX_BR = 8;
  localparam int PC_W   = 40;

  typedef struct {
    logic [63:0] op1;
    logic [63:0] op2;
    logic [13:0] ctrl;
    logic [7:0]  mask;
  } exp_t;

  logic              clock = 1'b0;
  logic              reset;
  logic [MAX_BR-1:0] resolve;
  logic [MAX_BR-1:0] mispredict;
  logic              flush;
  exp_t              sb[$];
  int                checks = 0;
  int                errors = 0;

  always #5 clock = ~clock;

  rrd_in_if #(.XLEN(XLEN), .MAX_BR(MAX_BR), .PC_W(PC_W)) in_if();
  rrd_out_if #(.XLEN(XLEN), .MAX_BR(MAX_BR)) out_if();

`ifdef RRD_WB_BYPASS_EN
  logic            wb_valid;
  logic [6:0]      wb_pdst;
  logic [XLEN-1:0] wb_data;
`endif

  rrd_operand_stage #(
    .XLEN(XLEN), .MAX_BR(MAX_BR), .PC_W(PC_W)
  ) dut (
    .clock                   (clock),
    .reset                   (reset),
    .io_in                   (in_if),
    .io_out                  (out_if),
    .io_brupd_resolve_mask   (resolve),
    .io_brupd_mispredict_mask(mispredict),
    .io_flush                (flush)
`ifdef RRD_WB_BYPASS_EN
    ,
    .io_wb_valid             (wb_valid),
    .io_wb_pdst              (wb_pdst),
    .io_wb_data              (wb_data)
`endif
  );

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic [1:0] s1, input logic [2:0] s2,
                       input logic [2:0] is, input logic [19:0] ip,
                       input logic rvc, input logic [6:0] p1,
                       input logic [7:0] m, input logic [13:0] c,
                       input logic [39:0] pc,
                       input logic [63:0] r1, input logic [63:0] r2);
    in_if.valid      = 1'b1;
    in_if.op1_sel    = s1;
    in_if.op2_sel    = s2;
    in_if.imm_sel    = is;
    in_if.imm_packed = ip;
    in_if.is_rvc     = rvc;
    in_if.prs1       = p1;
    in_if.br_mask    = m;
    in_if.ctrl       = c;
    in_if.pc         = pc;
    in_if.rs1_data   = r1;
    in_if.rs2_data   = r2;
  endtask

  task automatic expect_out(input logic [63:0] o1, input logic [63:0] o2,
                            input logic [13:0] c, input logic [7:0] m);
    exp_t e;
    e.op1 = o1; e.op2 = o2; e.ctrl = c; e.mask = m;
    sb.push_back(e);
  endtask

  // Monitor: a transfer happens on the next edge when valid && ready.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (!reset && out_if.valid && out_if.ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out actual op1=%h op2=%h required=none",
                   out_if.op1, out_if.op2);
        end else begin
          e = sb.pop_front();
          chk("out_op1", out_if.op1, e.op1);
          chk("out_op2", out_if.op2, e.op2);
          chk("out_ctrl", 64'(out_if.ctrl), 64'(e.ctrl));
          chk("out_br_mask", 64'(out_if.br_mask), 64'(e.mask));
        end
      end
    end
  end

  localparam logic [63:0] R1 = 64'h1111_2222_3333_4444;
  localparam logic [63:0] R2 = 64'h5555_6666_7777_8888;

  initial begin
    reset      = 1'b1;
    resolve    = '0;
    mispredict = '0;
    flush      = 1'b0;
    out_if.ready = 1'b0;
    drive(OP1_RS1, OP2_RS2, IMM_I, 20'h0, 1'b0, 7'd0,
          8'h0, 14'h0, 40'h0, 64'h0, 64'h0);
    in_if.valid = 1'b0;
`ifdef RRD_WB_BYPASS_EN
    in_if.prs2 = 7'd0;
    wb_valid   = 1'b0;
    wb_pdst    = 7'd0;
    wb_data    = '0;
`endif
    step();
    step();
    @(negedge clock);
    chk("rst_valid", 64'(out_if.valid), 64'd0);
    chk("rst_op1", out_if.op1, 64'd0);
    chk("rst_op2", out_if.op2, 64'd0);
    chk("rst_ctrl", 64'(out_if.ctrl), 64'd0);
    chk("rst_mask", 64'(out_if.br_mask), 64'd0);
    chk("rst_in_ready", 64'(in_if.ready), 64'd1);
    reset = 1'b0;
    step();

    // Back-to-back select / immediate vectors, execute always ready.
    out_if.ready = 1'b1;
    drive(OP1_RS1, OP2_IMM, IMM_I, 20'h80100, 1'b0, 7'd0,
          8'h01, 14'h1A5, 40'h0, R1, R2);
    expect_out(R1, 64'hFFFF_FFFF_FFFF_F801, 14'h1A5, 8'h01);
    step();
    drive(OP1_ZERO, OP2_IMM, IMM_U, 20'h12345, 1'b0, 7'd0,
          8'h02, 14'h2B6, 40'h0, R1, R2);
    expect_out(64'd0, 64'h0000_0000_1234_5000, 14'h2B6, 8'h02);
    step();
    drive(OP1_PC, OP2_NEXT, IMM_I, 20'h0, 1'b1, 7'd0,
          8'h00, 14'h0C3, 40'h00_8000_1000, R1, R2);
    expect_out(64'h8000_1000, 64'd2, 14'h0C3, 8'h00);
    step();
    drive(OP1_PC, OP2_NEXT, IMM_I, 20'h0, 1'b0, 7'd0,
          8'h00, 14'h0C4, 40'hAB_0000_0010, R1, R2);
    expect_out(64'hAB_0000_0010, 64'd4, 14'h0C4, 8'h00);
    step();
    drive(OP1_RS1, OP2_RS2, IMM_I, 20'h0, 1'b0, 7'd3,
          8'h80, 14'h3FFF, 40'h0, R1, R2);
    expect_out(R1, R2, 14'h3FFF, 8'h80);
    step();
    drive(OP1_ZERO, OP2_IMM, IMM_B, 20'h00302, 1'b0, 7'd0,
          8'h00, 14'h011, 40'h0, R1, R2);
    expect_out(64'd0, 64'h802, 14'h011, 8'h00);
    step();
    drive(OP1_ZERO, OP2_IMM, IMM_J, 20'h80012, 1'b0, 7'd0,
          8'h00, 14'h012, 40'h0, R1, R2);
    expect_out(64'd0, 64'hFFFF_FFFF_FFF1_2000, 14'h012, 8'h00);
    step();
    drive(OP1_ZERO, OP2_IMM, IMM_S, 20'h00F00, 1'b0, 7'd0,
          8'h00, 14'h013, 40'h0, R1, R2);
    expect_out(64'd0, 64'hF, 14'h013, 8'h00);
    step();
    drive(OP1_ZERO, OP2_IMM, IMM_Z, 20'hFFFFF, 1'b0, 7'h6A,
          8'h00, 14'h014, 40'h0, R1, R2);
    expect_out(64'd0, 64'hA, 14'h014, 8'h00);
    step();
    drive(OP1_RS1, OP2_IMMC, IMM_I, 20'hFFFFF, 1'b0, 7'h5F,
          8'h00, 14'h015, 40'h0, R1, R2);
    expect_out(R1, 64'h1F, 14'h015, 8'h00);
    step();
    drive(2'd3, 3'd5, IMM_I, 20'hFFFFF, 1'b0, 7'h1F,
          8'h00, 14'h016, 40'hFF, R1, R2);
    expect_out(64'd0, 64'd0, 14'h016, 8'h00);
    step();
    drive(OP1_RS1, OP2_IMM, 3'd6, 20'hFFFFF, 1'b0, 7'h1F,
          8'h00, 14'h017, 40'h0, R1, R2);
    expect_out(R1, 64'd0, 14'h017, 8'h00);
    step();
    in_if.valid = 1'b0;
    step();
    step();

    // Stall: A held three cycles while B waits, then both drain.
    out_if.ready = 1'b0;
    drive(OP1_RS1, OP2_IMM, IMM_I, 20'h80100, 1'b0, 7'd0,
          8'h00, 14'h0AA, 40'h0, R1, R2);
    expect_out(R1, 64'hFFFF_FFFF_FFFF_F801, 14'h0AA, 8'h00);
    step();
    drive(OP1_ZERO, OP2_RS2, IMM_I, 20'h0, 1'b0, 7'd0,
          8'h00, 14'h0BB, 40'h0, R2, R1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      chk("stall_in_ready", 64'(in_if.ready), 64'd0);
      chk("stall_op1", out_if.op1, R1);
      chk("stall_op2", out_if.op2, 64'hFFFF_FFFF_FFFF_F801);
      step();
    end
    out_if.ready = 1'b1;
    expect_out(64'd0, R1, 14'h0BB, 8'h00);
    step();
    in_if.valid = 1'b0;
    step();
    step();

    // Resolve while held: mask 0x0C loses bit 2, uop survives.
    out_if.ready = 1'b0;
    drive(OP1_ZERO, OP2_RS2, IMM_I, 20'h0, 1'b0, 7'd0,
          8'h0C, 14'h0CC, 40'h0, R1, R2);
    expect_out(64'd0, R2, 14'h0CC, 8'h08);
    step();
    in_if.valid = 1'b0;
    resolve = 8'h04;
    step();
    resolve = 8'h00;
    @(negedge clock);
    chk("resolve_valid", 64'(out_if.valid), 64'd1);
    chk("resolve_mask", 64'(out_if.br_mask), 64'h08);
    step();
    out_if.ready = 1'b1;
    step();
    step();

    // Resolve on capture, and unrelated mispredict leaves uop alive.
    drive(OP1_RS1, OP2_ZERO, IMM_I, 20'h0, 1'b0, 7'd0,
          8'h03, 14'h0DD, 40'h0, R1, R2);
    resolve = 8'h01;
    expect_out(R1, 64'd0, 14'h0DD, 8'h02);
    step();
    resolve = 8'h00;
    drive(OP1_RS1, OP2_RS2, IMM_I, 20'h0, 1'b0, 7'd0,
          8'h02, 14'h0DE, 40'h0, R2, R1);
    mispredict = 8'h01;
    expect_out(R2, R1, 14'h0DE, 8'h02);
    step();
    mispredict = 8'h00;
    in_if.valid = 1'b0;
    step();
    step();

    // Mispredict kills a held uop.
    out_if.ready = 1'b0;
    drive(OP1_RS1, OP2_RS2, IMM_I, 20'h0, 1'b0, 7'd0,
          8'h04, 14'h0EE, 40'h0, R1, R2);
    step();
    in_if.valid = 1'b0;
    mispredict = 8'h04;
    step();
    mispredict = 8'h00;
    @(negedge clock);
    chk("held_kill_valid", 64'(out_if.valid), 64'd0);
    chk("held_kill_in_ready", 64'(in_if.ready), 64'd1);
    step();

    // Mispredict and flush drop an incoming uop.
    out_if.ready = 1'b1;
    drive(OP1_RS1, OP2_RS2, IMM_I, 20'h0, 1'b0, 7'd0,
          8'h10, 14'h0EF, 40'h0, R1, R2);
    mispredict = 8'h10;
    step();
    mispredict = 8'h00;
    in_if.valid = 1'b0;
    @(negedge clock);
    chk("in_kill_valid", 64'(out_if.valid), 64'd0);
    step();
    drive(OP1_RS1, OP2_RS2, IMM_I, 20'h0, 1'b0, 7'd0,
          8'h00, 14'h0F0, 40'h0, R1, R2);
    flush = 1'b1;
    step();
    flush = 1'b0;
    in_if.valid = 1'b0;
    @(negedge clock);
    chk("flush_valid", 64'(out_if.valid), 64'd0);
    step();

    // Reset while a uop is held.
    out_if.ready = 1'b0;
    drive(OP1_RS1, OP2_RS2, IMM_I, 20'h0, 1'b0, 7'd0,
          8'h20, 14'h0F1, 40'h0, R1, R2);
    step();
    in_if.valid = 1'b0;
    @(negedge clock);
    chk("pre_rst_valid", 64'(out_if.valid), 64'd1);
    step();
    reset = 1'b1;
    step();
    @(negedge clock);
    chk("mid_rst_valid", 64'(out_if.valid), 64'd0);
    chk("mid_rst_op1", out_if.op1, 64'd0);
    chk("mid_rst_op2", out_if.op2, 64'd0);
    chk("mid_rst_ctrl", 64'(out_if.ctrl), 64'd0);
    chk("mid_rst_mask", 64'(out_if.br_mask), 64'd0);
    reset = 1'b0;
    step();
    out_if.ready = 1'b1;

`ifdef RRD_WB_BYPASS_EN
    wb_valid = 1'b1;
    wb_pdst  = 7'd5;
    wb_data  = 64'hDEAD_BEEF_0000_0005;
    drive(OP1_RS1, OP2_RS2, IMM_I, 20'h0, 1'b0, 7'd5,
          8'h00, 14'h101, 40'h0, R1, R2);
    in_if.prs2 = 7'd5;
    expect_out(64'hDEAD_BEEF_0000_0005, 64'hDEAD_BEEF_0000_0005,
               14'h101, 8'h00);
    step();
    wb_pdst = 7'd0;
    drive(OP1_RS1, OP2_RS2, IMM_I, 20'h0, 1'b0, 7'd0,
          8'h00, 14'h102, 40'h0, R1, R2);
    in_if.prs2 = 7'd0;
    expect_out(R1, R2, 14'h102, 8'h00);
    step();
    wb_valid = 1'b0;
    in_if.valid = 1'b0;
`endif

    for (int i = 0; i < 20 && sb.size() != 0; i++) step();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout actual=%0d pending required=0",
               sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
